// File: rtl/adapter_bus_sched_pkg.sv
// rtl/adapter_bus_sched_pkg.sv - shared types and constants for the adapter bus scheduler
package adapter_bus_sched_pkg;

    localparam int SIZE_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        CLEAR = 2'd2
    } state_e;

    // Width of a producer index; a single producer still needs one bit of port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adapter_bus_sched_rr_pick.sv
// rtl/adapter_bus_sched_rr_pick.sv - combinational round-robin priority picker
module rr_pick
    import adapter_bus_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0] cand;

    // First requester at or above ptr, wrapping; ptr itself has top priority.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!any && req[cand[IW-1:0]]) begin
                any = 1'b1;
                idx = cand[IW-1:0];
            end
        end
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/adapter_bus_sched.sv
// rtl/adapter_bus_sched.sv - round-robin owner of a shared wide-to-narrow adapter with watchdog
module adapter_bus_sched
    import adapter_bus_sched_pkg::*;
#(
    parameter int  NREQ    = 4,
    parameter int  width   = 128,
    parameter int  owidth  = 32,
    parameter int  TIMEOUT = 1024,
    localparam int IW      = idx_w(NREQ)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req_enq__ENA,
    output logic [NREQ-1:0]          req_enq__RDY,
    input  logic [NREQ*width-1:0]    req_enq_v,
    input  logic [NREQ*SIZE_W-1:0]   req_enq_size,
    output logic                     adp_enq__ENA,
    input  logic                     adp_enq__RDY,
    output logic [width-1:0]         adp_enq_v,
    output logic [SIZE_W-1:0]        adp_enq_size,
    input  logic                     adp_deq__ENA,
    input  logic                     adp_last,
    output logic                     adp_clear__ENA,
    output logic [IW-1:0]            owner,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [SIZE_W-1:0]        beat_cnt
);

    localparam int WD_W = $clog2(TIMEOUT);

    if (owidth < 1 || owidth > width) begin : g_bad_owidth
        $error("adapter_bus_sched: owidth must lie in 1..width");
    end
    if (NREQ < 2 || NREQ > 16 || TIMEOUT < 2) begin : g_bad_params
        $error("adapter_bus_sched: NREQ must be 2..16 and TIMEOUT at least 2");
    end

    state_e            state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic              busy_q, busy_d;
    logic [SIZE_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              timeout_err_q, timeout_err_d;

    logic [NREQ-1:0]   pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              grant_open;
    logic              accept;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req (req_enq__ENA),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Handshake side: only an idle, non-reset scheduler offers the adapter to the winner.
    always_comb begin
        grant_open     = (state_q == IDLE) && !RST;
        adp_enq__ENA   = grant_open && pick_any;
        req_enq__RDY   = (grant_open && adp_enq__RDY) ? pick_gnt : '0;
        adp_enq_v      = req_enq_v[pick_idx*width +: width];
        adp_enq_size   = req_enq_size[pick_idx*SIZE_W +: SIZE_W];
        adp_clear__ENA = (state_q == CLEAR) && !RST;
        accept         = adp_enq__ENA && adp_enq__RDY;
    end

    // Next-state: grant in IDLE, count beats and stalls in BUSY, one-cycle forced clear.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        beat_cnt_d    = beat_cnt_q;
        wdog_d        = wdog_q;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rr_ptr_d   = (pick_idx == IW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    wdog_d     = '0;
                    // A zero-length message produces no beats, so the grant ends here.
                    if (adp_enq_size != '0) begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (adp_deq__ENA) begin
                    if (beat_cnt_q != '1) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                    wdog_d = '0;
                    if (adp_last) begin
                        state_d = IDLE;
                    end
                end else begin
                    wdog_d = wdog_q + 1'b1;
                    if (wdog_d == WD_W'(TIMEOUT-1)) begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                // Any beat seen here belongs to the message being thrown away.
                timeout_err_d = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            busy_q        <= 1'b0;
            beat_cnt_q    <= '0;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            busy_q        <= busy_d;
            beat_cnt_q    <= beat_cnt_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign owner       = owner_q;
    assign busy        = busy_q;
    assign beat_cnt    = beat_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule
